blake2_input_driver: RTL and testbench
======================================

Name: blake2_input_driver

Overview:
- Host-side transmitter for the Blake2 byte-stream command interface (valid/cmd/data).
- Accepts a configuration triple (kk, nn, ll) and whole 512-bit message blocks through valid/ready handshakes.
- Serializes them one byte per cycle with the correct CONF/START/DATA/LAST commands.
- Drives the input FSM of the hash core; also used as the stimulus front-end in system benches.

Parameters:
- BLOCK_BYTES, 64, bytes per message block; fixed to 64 for Blake2s; counter width is log2(BLOCK_BYTES).
- CONF_BYTES, 3, configuration bytes emitted in order kk, nn, ll.

Ports:
- clk  in  1  clock
- nreset  in  1  reset; asynchronous, active-low
- cfg_v_i  in  1  configuration valid
- cfg_ready_o  out  1  configuration accepted when high together with cfg_v_i
- kk_i  in  8  key length in bytes
- nn_i  in  8  digest length in bytes
- ll_i  in  8  message length field
- block_v_i  in  1  block valid
- block_ready_o  out  1  block accepted when high together with block_v_i
- block_i  in  512  block data; byte i = block_i[8*i+7:8*i]
- block_first_i  in  1  block is the first block of the message
- block_last_i  in  1  block is the last block of the message
- valid_o  out  1  byte-stream valid
- cmd_o  out  2  command: 0 CONF, 1 START, 2 DATA, 3 LAST
- data_o  out  8  byte-stream data
- done_o  out  1  one-cycle pulse after the last byte of a last block

Behaviour:
- Reset (async, nreset low):
  - state=IDLE; cnt_q=0.
  - valid_o=0, cmd_o=0, data_o=0, done_o=0.
  - cfg_ready_o=1 and block_ready_o=1, because both decode the IDLE state; upstream must hold valids low during reset.
- Outputs valid_o/cmd_o/data_o/done_o are registered. Byte 0 appears the cycle after acceptance (latency 1).
- State IDLE:
  - cfg_ready_o=1.
  - block_ready_o=~cfg_v_i; config has priority when both valids are high.
  - Config accepted: latch kk/nn/ll, cnt_q<=0, go to CONF.
  - Block accepted: latch block/first/last, cnt_q<=0, go to BLOCK.
- State CONF:
  - One byte per cycle: valid_o=1, cmd_o=0, data_o = kk, then nn, then ll.
  - After the ll byte, return to IDLE.
  - Both ready outputs are 0.
- State BLOCK:
  - One byte per cycle, byte cnt_q, cnt_q increments by 1.
  - cmd_o per byte:
    - START if cnt_q==0 and first_q;
    - else LAST if last_q;
    - else DATA.
  - A single-block message (first and last both set) gives byte 0 = START and bytes 1..63 = LAST.
  - cfg_ready_o=0.
  - block_ready_o=1 only while the byte with cnt_q==63 is being issued.
    - If a block is accepted then, the new block is loaded, cnt_q wraps 63->0 and the state stays BLOCK. Output is gapless (no idle cycle).
    - Otherwise the state returns to IDLE and valid_o drops the next cycle.
- done_o: asserted for 1 cycle, the cycle after byte 63 of a block with last_q=1 was emitted.
- Counter widths:
  - cnt_q is 6 bits and wraps modulo 64 with no overflow flag.
  - The CONF byte index uses the low 2 bits of cnt_q; the value 3 is never reached.
- Reset mid-transfer: all outputs go to reset values immediately (async). The partial block is discarded and no done_o is produced.
- Handshake inputs (cfg_v_i, block_v_i) are ignored whenever the matching ready is 0.
- Input data is sampled only on handshake and held internally; upstream may change block_i after acceptance.

Optional Feature:
- Macro: BLAKE2_DRV_STALL_EN.
- Defined:
  - Adds input port stall_i (1 bit).
  - While stall_i=1: valid_o=0 in that cycle, cnt_q and state are frozen, and both ready outputs are 0.
  - Emission resumes with the same byte when stall_i returns to 0. done_o timing shifts by the number of stalled cycles.
- Undefined: no stall_i port; the stream is emitted without gaps as described above.

Test Plan:
- Config: kk=0x00, nn=0x20, ll=0x03 -> 3 consecutive cycles with valid_o=1, cmd_o=0, data_o=0x00, 0x20, 0x03. cfg_ready_o is low for those 3 cycles and high after.
- Single block, first=1, last=1, byte i=i -> 64 valid cycles; byte 0 cmd=1 data=0x00; bytes 1..63 cmd=3 data=0x01..0x3F; done_o pulses once, the cycle after data=0x3F.
- Two blocks: first (bytes 0xAA) then last (bytes 0x55), second offered during the first's byte 63 -> 128 contiguous valid cycles. Cmds: START, DATA x63, then LAST x64. Exactly one done_o.
- Simultaneous cfg_v_i and block_v_i in IDLE -> 3 CONF bytes first. The block is accepted on the first IDLE cycle after CONF, with block_ready_o=0 during CONF.
- nreset asserted at byte 20 of a block -> valid_o=0 the same cycle, no done_o. After release, a new config streams correctly from kk.
- BLAKE2_DRV_STALL_EN: stall_i held high for 5 cycles at byte 10 -> valid_o low for 5 cycles, then byte 10 is re-presented. The total transfer takes 69 cycles.

Source files
------------

// File: rtl/blake2_input_driver.sv
// blake2_input_driver: serializes a (kk, nn, ll) config or 512-bit blocks into the Blake2 valid/cmd/data byte stream.
// Optional BLAKE2_DRV_STALL_EN adds stall_i, which freezes emission and blanks valid_o.
module blake2_input_driver #(
   parameter int BLOCK_BYTES = 64,
   parameter int CONF_BYTES  = 3
) (
   input  logic                     clk,
   input  logic                     nreset,
`ifdef BLAKE2_DRV_STALL_EN
   input  logic                     stall_i,
`endif
   input  logic                     cfg_v_i,
   output logic                     cfg_ready_o,
   input  logic [7:0]               kk_i,
   input  logic [7:0]               nn_i,
   input  logic [7:0]               ll_i,
   input  logic                     block_v_i,
   output logic                     block_ready_o,
   input  logic [8*BLOCK_BYTES-1:0] block_i,
   input  logic                     block_first_i,
   input  logic                     block_last_i,
   output logic                     valid_o,
   output logic [1:0]               cmd_o,
   output logic [7:0]               data_o,
   output logic                     done_o
);
   localparam int CW = $clog2(BLOCK_BYTES);
   typedef enum logic [1:0] {IDLE, CONF, BLOCK} state_t;
   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [7:0]               kk_q, nn_q, ll_q, kk_d, nn_d, ll_d, data_d;
   logic [8*BLOCK_BYTES-1:0] blk_q, blk_d;
   logic                     first_q, last_q, first_d, last_d;
   logic                     stall, cfg_acc, blk_acc, cnt_end, conf_end;
   logic                     valid_q, valid_d, done_d;
   logic [1:0]               cmd_d;
`ifdef BLAKE2_DRV_STALL_EN
   assign stall = stall_i;
`else
   assign stall = 1'b0;
`endif
   assign cnt_end       = cnt_q == CW'(BLOCK_BYTES - 1);
   assign conf_end      = cnt_q == CW'(CONF_BYTES - 1);
   assign cfg_ready_o   = state_q == IDLE && !stall;
   assign block_ready_o = !stall && (state_q == IDLE ? !cfg_v_i : state_q == BLOCK && cnt_end);
   assign cfg_acc       = cfg_v_i && cfg_ready_o;
   assign blk_acc       = block_v_i && block_ready_o;
   assign valid_o       = valid_q && !stall;
   // Outputs are computed from next-state values so byte 0 is visible the cycle after acceptance.
   always_comb begin
      state_d = stall ? state_q : cfg_acc ? CONF : blk_acc ? BLOCK :
                state_q == CONF ? (conf_end ? IDLE : CONF) :
                state_q == BLOCK ? (cnt_end ? IDLE : BLOCK) : IDLE;
      cnt_d   = stall ? cnt_q :
                (cfg_acc || state_q == IDLE || (state_q == CONF && conf_end)) ? '0 : cnt_q + CW'(1);
      kk_d    = cfg_acc ? kk_i : kk_q;
      nn_d    = cfg_acc ? nn_i : nn_q;
      ll_d    = cfg_acc ? ll_i : ll_q;
      blk_d   = blk_acc ? block_i : blk_q;
      first_d = blk_acc ? block_first_i : first_q;
      last_d  = blk_acc ? block_last_i : last_q;
      valid_d = state_d != IDLE;
      data_d  = state_d == IDLE ? 8'd0 :
                state_d == CONF ? (cnt_d[1:0] == 2'd0 ? kk_d : cnt_d[1:0] == 2'd1 ? nn_d : ll_d) :
                blk_d[{cnt_d, 3'b000} +: 8];
      cmd_d   = state_d != BLOCK ? 2'd0 : (cnt_d == '0 && first_d) ? 2'd1 : last_d ? 2'd3 : 2'd2;
      done_d  = !stall && state_q == BLOCK && cnt_end && last_q;
   end
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         kk_q    <= '0;
         nn_q    <= '0;
         ll_q    <= '0;
         blk_q   <= '0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         cmd_o   <= '0;
         data_o  <= '0;
         done_o  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kk_q    <= kk_d;
         nn_q    <= nn_d;
         ll_q    <= ll_d;
         blk_q   <= blk_d;
         first_q <= first_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         cmd_o   <= cmd_d;
         data_o  <= data_d;
         done_o  <= done_d;
      end
   end
endmodule

// File: tb/tb_blake2_input_driver.sv
// tb_blake2_input_driver: scoreboard bench for blake2_input_driver (default build, no stall port).
module tb_blake2_input_driver;
   typedef struct {
      logic [1:0] cmd;
      logic [7:0] data;
      bit         done;
   } ent_t;
   logic         clk = 1'b0, nreset = 1'b0;
   logic         cfg_v_i = 1'b0, block_v_i = 1'b0, block_first_i = 1'b0, block_last_i = 1'b0;
   logic [7:0]   kk_i = '0, nn_i = '0, ll_i = '0;
   logic [511:0] block_i = '0;
   logic         cfg_ready_o, block_ready_o, valid_o, done_o;
   logic [1:0]   cmd_o;
   logic [7:0]   data_o;
   int           checks = 0, failures = 0, done_cnt = 0, cyc = 0, t0;
   ent_t         q[$];
   bit           done_pend = 0;

   blake2_input_driver dut (
      .clk(clk), .nreset(nreset),
      .cfg_v_i(cfg_v_i), .cfg_ready_o(cfg_ready_o),
      .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
      .block_v_i(block_v_i), .block_ready_o(block_ready_o), .block_i(block_i),
      .block_first_i(block_first_i), .block_last_i(block_last_i),
      .valid_o(valid_o), .cmd_o(cmd_o), .data_o(data_o), .done_o(done_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: each valid byte pops one expected entry; done_o must follow the flagged entry by one cycle.
   always @(negedge clk) begin
      bit   exp_done;
      ent_t e;
      if (!nreset) done_pend = 0;
      else begin
         exp_done  = done_pend;
         done_pend = 0;
         if (done_o) done_cnt++;
         if (done_o || exp_done) begin
            checks++;
            if (done_o !== exp_done) begin
               failures++;
               $display("FAIL done_o got=%b exp=%b t=%0t", done_o, exp_done, $time);
            end
         end
         if (valid_o) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL stream unexpected byte cmd=%0d data=%h t=%0t", cmd_o, data_o, $time);
            end else begin
               e = q.pop_front();
               done_pend = e.done;
               if ({cmd_o, data_o} !== {e.cmd, e.data}) begin
                  failures++;
                  $display("FAIL stream got cmd=%0d data=%h exp cmd=%0d data=%h t=%0t",
                           cmd_o, data_o, e.cmd, e.data, $time);
               end
            end
         end
      end
   end

   task automatic push(input logic [1:0] c, input logic [7:0] d, input bit dn);
      ent_t e;
      e.cmd = c; e.data = d; e.done = dn;
      q.push_back(e);
   endtask

   task automatic wait_block_ready();
      int n = 0;
      @(negedge clk);
      while (!block_ready_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!block_ready_o) begin
         checks++;
         failures++;
         $display("FAIL block_ready timeout got=0 exp=1");
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   task automatic send_cfg(input logic [7:0] k, input logic [7:0] n, input logic [7:0] l);
      push(2'd0, k, 0); push(2'd0, n, 0); push(2'd0, l, 0);
      kk_i = k; nn_i = n; ll_i = l; cfg_v_i = 1'b1;
      @(negedge clk);
      checks++;
      if (cfg_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready_o);
      end
      @(posedge clk); #1;
      cfg_v_i = 1'b0; kk_i = 8'hEE; nn_i = 8'hEE; ll_i = 8'hEE;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({valid_o, cmd_o, data_o, done_o} !== 12'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b_%0d_%h_%b exp=0_0_00_0", valid_o, cmd_o, data_o, done_o);
      end
      checks++;
      if ({cfg_ready_o, block_ready_o} !== 2'b11) begin
         failures++;
         $display("FAIL reset_ready got=%b%b exp=11", cfg_ready_o, block_ready_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) nreset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_config();
      send_cfg(8'h00, 8'h20, 8'h03);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({valid_o, cfg_ready_o} !== 2'b10) begin
            failures++;
            $display("FAIL conf_cycle%0d valid/cfg_ready got=%b%b exp=10", i, valid_o, cfg_ready_o);
         end
      end
      @(negedge clk);
      checks++;
      if ({valid_o, cfg_ready_o} !== 2'b01) begin
         failures++;
         $display("FAIL conf_after valid/cfg_ready got=%b%b exp=01", valid_o, cfg_ready_o);
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL conf_drain left=%0d exp=0", q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_block();
      done_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         block_i[8*i +: 8] = 8'(i);
         push(i == 0 ? 2'd1 : 2'd3, 8'(i), i == 63);
      end
      block_first_i = 1'b1; block_last_i = 1'b1; block_v_i = 1'b1;
      wait_block_ready();
      @(posedge clk); #1;
      t0 = cyc;
      block_v_i = 1'b0; block_i = '1;
      drain();
      checks++;
      if (cyc - t0 != 64) begin
         failures++;
         $display("FAIL single_len got=%0d exp=64", cyc - t0);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL single_done_count got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_back_to_back();
      done_cnt = 0;
      for (int i = 0; i < 64; i++) push(i == 0 ? 2'd1 : 2'd2, 8'hAA, 0);
      block_i = {64{8'hAA}}; block_first_i = 1'b1; block_last_i = 1'b0; block_v_i = 1'b1;
      wait_block_ready();
      @(posedge clk); #1;
      t0 = cyc;
      for (int i = 0; i < 64; i++) push(2'd3, 8'h55, i == 63);
      block_i = {64{8'h55}}; block_first_i = 1'b0; block_last_i = 1'b1;
      wait_block_ready();
      @(posedge clk); #1;
      block_v_i = 1'b0;
      drain();
      checks++;
      if (cyc - t0 != 128) begin
         failures++;
         $display("FAIL b2b_len got=%0d exp=128", cyc - t0);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (done_cnt != 1) begin
         failures++;
         $display("FAIL b2b_done_count got=%0d exp=1", done_cnt);
      end
   endtask

   task automatic test_priority();
      done_cnt = 0;
      push(2'd0, 8'h01, 0); push(2'd0, 8'h02, 0); push(2'd0, 8'h03, 0);
      for (int i = 0; i < 64; i++) begin
         block_i[8*i +: 8] = 8'(8'h80 + i);
         push(2'd2, 8'(8'h80 + i), 0);
      end
      kk_i = 8'h01; nn_i = 8'h02; ll_i = 8'h03;
      block_first_i = 1'b0; block_last_i = 1'b0;
      cfg_v_i = 1'b1; block_v_i = 1'b1;
      @(negedge clk);
      checks++;
      if ({cfg_ready_o, block_ready_o} !== 2'b10) begin
         failures++;
         $display("FAIL prio_ready got=%b%b exp=10", cfg_ready_o, block_ready_o);
      end
      @(posedge clk); #1;
      t0 = cyc;
      cfg_v_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (block_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL prio_conf%0d block_ready got=%b exp=0", i, block_ready_o);
         end
      end
      @(negedge clk);
      checks++;
      if (block_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL prio_idle block_ready got=%b exp=1", block_ready_o);
      end
      @(posedge clk); #1;
      block_v_i = 1'b0;
      drain();
      checks++;
      if (cyc - t0 != 68) begin
         failures++;
         $display("FAIL prio_len got=%0d exp=68", cyc - t0);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (done_cnt != 0) begin
         failures++;
         $display("FAIL prio_done_count got=%0d exp=0", done_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      done_cnt = 0;
      for (int i = 0; i < 64; i++) begin
         block_i[8*i +: 8] = 8'(8'h40 + i);
         push(i == 0 ? 2'd1 : 2'd3, 8'(8'h40 + i), i == 63);
      end
      block_first_i = 1'b1; block_last_i = 1'b1; block_v_i = 1'b1;
      wait_block_ready();
      @(posedge clk); #1;
      block_v_i = 1'b0;
      while (q.size() > 44 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #2 nreset = 1'b0;
      q.delete();
      #1;
      checks++;
      if ({valid_o, cmd_o, data_o, done_o} !== 12'd0) begin
         failures++;
         $display("FAIL midreset_outputs got=%b_%0d_%h_%b exp=0_0_00_0", valid_o, cmd_o, data_o, done_o);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) nreset = 1'b1;
      @(posedge clk); #1;
      send_cfg(8'h11, 8'h22, 8'h33);
      t0 = cyc - 1;
      drain();
      checks++;
      if (cyc - t0 != 4) begin
         failures++;
         $display("FAIL midreset_cfg_len got=%0d exp=4", cyc - t0);
      end
      repeat (80) @(posedge clk); #1;
      checks++;
      if (done_cnt != 0) begin
         failures++;
         $display("FAIL midreset_done_count got=%0d exp=0", done_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_config();
      test_single_block();
      test_back_to_back();
      test_priority();
      test_reset_mid();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL final_drain left=%0d exp=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
